// File: rtl/spi_reg_arbiter.sv
// Arbitrates a single-ported register file between a SPI slave (one-entry pending slot) and a core port.
// Define SPI_ARB_STARVE_GUARD_EN to let a waiting core win after STARVE_LIMIT consecutive SPI grants.
module spi_reg_arbiter #(
  parameter int ADDR_W       = 3,
  parameter int REG_W        = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              ena,
  input  logic [ADDR_W-1:0] spi_addr,
  input  logic              spi_rd_v,
  input  logic [REG_W-1:0]  spi_wdata,
  input  logic              spi_wr_v,
  output logic [REG_W-1:0]  spi_rdata,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [REG_W-1:0]  core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [REG_W-1:0]  core_rdata,
  output logic              rf_en,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [REG_W-1:0]  rf_wdata,
  input  logic [REG_W-1:0]  rf_rdata,
  output logic              ovf
);

  typedef enum logic [2:0] {IDLE, SPI_ACC, SPI_RSP, CORE_ACC, CORE_RSP} state_t;

  state_t              state_reg;
  logic                slot_v_reg;
  logic                slot_we_reg;
  logic [ADDR_W-1:0]   slot_addr_reg;
  logic [REG_W-1:0]    slot_wdata_reg;
  logic                acc_we_reg;
  logic [ADDR_W-1:0]   acc_addr_reg;
  logic [REG_W-1:0]    acc_wdata_reg;
  logic [REG_W-1:0]    spi_rdata_reg;
  logic [REG_W-1:0]    core_rdata_reg;
  logic                ovf_reg;

  logic spi_pulse;
  logic slot_accept;
  logic core_first;
  logic rf_active;

  assign spi_pulse   = spi_wr_v | spi_rd_v;
  // The slot empties at the end of SPI_ACC, so a pulse landing there refills it.
  assign slot_accept = spi_pulse && (!slot_v_reg || (state_reg == SPI_ACC));

`ifdef SPI_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 2);
  logic [CNT_W-1:0] starve_cnt_reg;
  assign core_first = core_req && (starve_cnt_reg >= CNT_W'(STARVE_LIMIT));
`else
  assign core_first = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_reg      <= IDLE;
      slot_v_reg     <= 1'b0;
      slot_we_reg    <= 1'b0;
      slot_addr_reg  <= '0;
      slot_wdata_reg <= '0;
      acc_we_reg     <= 1'b0;
      acc_addr_reg   <= '0;
      acc_wdata_reg  <= '0;
      spi_rdata_reg  <= '0;
      core_rdata_reg <= '0;
      ovf_reg        <= 1'b0;
`ifdef SPI_ARB_STARVE_GUARD_EN
      starve_cnt_reg <= '0;
`endif
    end else if (ena) begin
      if (slot_accept) begin
        slot_v_reg     <= 1'b1;
        slot_we_reg    <= spi_wr_v;
        slot_addr_reg  <= spi_addr;
        slot_wdata_reg <= spi_wdata;
      end else if (state_reg == SPI_ACC) begin
        slot_v_reg <= 1'b0;
      end
      if (spi_pulse && !slot_accept)
        ovf_reg <= 1'b1;

      case (state_reg)
        IDLE: begin
          if (slot_v_reg && !core_first) begin
            state_reg     <= SPI_ACC;
            acc_we_reg    <= slot_we_reg;
            acc_addr_reg  <= slot_addr_reg;
            acc_wdata_reg <= slot_wdata_reg;
`ifdef SPI_ARB_STARVE_GUARD_EN
            if (core_req && (starve_cnt_reg < CNT_W'(STARVE_LIMIT)))
              starve_cnt_reg <= starve_cnt_reg + 1'b1;
`endif
          end else if (core_req) begin
            state_reg     <= CORE_ACC;
            acc_we_reg    <= core_we;
            acc_addr_reg  <= core_addr;
            acc_wdata_reg <= core_wdata;
`ifdef SPI_ARB_STARVE_GUARD_EN
            starve_cnt_reg <= '0;
`endif
          end
        end
        SPI_ACC:  state_reg <= SPI_RSP;
        SPI_RSP: begin
          if (!acc_we_reg)
            spi_rdata_reg <= rf_rdata;
          state_reg <= IDLE;
        end
        CORE_ACC: state_reg <= CORE_RSP;
        CORE_RSP: begin
          if (!acc_we_reg)
            core_rdata_reg <= rf_rdata;
          state_reg <= IDLE;
        end
        default:  state_reg <= IDLE;
      endcase
    end
  end

  // Strobes decode straight from the state register so ena can mask them without losing the access.
  assign rf_active   = ena && ((state_reg == SPI_ACC) || (state_reg == CORE_ACC));
  assign rf_en       = rf_active;
  assign rf_we       = rf_active && acc_we_reg;
  assign rf_addr     = rf_active ? acc_addr_reg : '0;
  assign rf_wdata    = rf_active ? acc_wdata_reg : '0;
  assign core_gnt    = ena && (state_reg == CORE_ACC);
  assign core_rvalid = ena && (state_reg == CORE_RSP) && !acc_we_reg;
  // Forward the register-file data during the rvalid cycle so data and pulse line up.
  assign core_rdata  = core_rvalid ? rf_rdata : core_rdata_reg;
  assign spi_rdata   = spi_rdata_reg;
  assign ovf         = ovf_reg;

endmodule

// File: tb/tb_spi_reg_arbiter.sv
// Directed bench for spi_reg_arbiter with a one-cycle-latency register-file model.
module tb_spi_reg_arbiter;
  logic       clk = 1'b0;
  logic       rstb, ena;
  logic [2:0] spi_addr;
  logic       spi_rd_v, spi_wr_v;
  logic [7:0] spi_wdata, spi_rdata;
  logic       core_req, core_we, core_gnt, core_rvalid;
  logic [2:0] core_addr;
  logic [7:0] core_wdata, core_rdata;
  logic       rf_en, rf_we, ovf;
  logic [2:0] rf_addr;
  logic [7:0] rf_wdata;
  logic [7:0] rf_rdata = 8'h00;
  logic [7:0] mem [0:7] = '{8'h00, 8'h5A, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  int n_checks = 0;
  int n_fail   = 0;

  spi_reg_arbiter #(.ADDR_W(3), .REG_W(8), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rstb(rstb), .ena(ena),
    .spi_addr(spi_addr), .spi_rd_v(spi_rd_v), .spi_wdata(spi_wdata), .spi_wr_v(spi_wr_v),
    .spi_rdata(spi_rdata),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .rf_en(rf_en), .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
    .rf_rdata(rf_rdata), .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rf_en) begin
      if (rf_we) mem[rf_addr] <= rf_wdata;
      rf_rdata <= mem[rf_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int spi_grants, gnt_count, first_gnt_spi;

  initial begin
    rstb = 1'b0; ena = 1'b1;
    spi_addr = '0; spi_rd_v = 1'b0; spi_wr_v = 1'b0; spi_wdata = '0;
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    tick(); tick();
    check("rst_rf_en", rf_en, 0);
    check("rst_core_gnt", core_gnt, 0);
    check("rst_rvalid", core_rvalid, 0);
    check("rst_spi_rdata", spi_rdata, 0);
    check("rst_core_rdata", core_rdata, 0);
    check("rst_ovf", ovf, 0);
    rstb = 1'b1;

    // SPI write: strobe appears two cycles after the pulse
    spi_wr_v = 1'b1; spi_addr = 3'd5; spi_wdata = 8'hA5;
    tick(); spi_wr_v = 1'b0;
    check("wr_c1_rf_en", rf_en, 0);
    tick();
    check("wr_rf_en", rf_en, 1);
    check("wr_rf_we", rf_we, 1);
    check("wr_rf_addr", rf_addr, 5);
    check("wr_rf_wdata", rf_wdata, 8'hA5);
    check("wr_core_gnt", core_gnt, 0);
    tick();
    check("wr_rsp_rf_en", rf_en, 0);
    check("wr_rsp_wdata", rf_wdata, 0);
    tick();
    check("wr_mem5", mem[5], 8'hA5);

    // SPI read of address 2
    spi_rd_v = 1'b1; spi_addr = 3'd2;
    tick(); spi_rd_v = 1'b0;
    tick();
    check("rd_rf_en", rf_en, 1);
    check("rd_rf_we", rf_we, 0);
    check("rd_rf_addr", rf_addr, 2);
    tick();
    check("rd_early_rdata", spi_rdata, 0);
    tick();
    check("rd_spi_rdata", spi_rdata, 8'h3C);
    tick(); tick();
    check("rd_held", spi_rdata, 8'h3C);

    // ena=0 ignores SPI pulses and freezes an in-flight access
    ena = 1'b0; spi_wr_v = 1'b1; spi_addr = 3'd6; spi_wdata = 8'h77;
    tick(); spi_wr_v = 1'b0; ena = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("ena_ignored_rf_en", rf_en, 0);
    end
    check("ena_no_ovf", ovf, 0);
    check("ena_mem6", mem[6], 0);
    spi_wr_v = 1'b1; spi_addr = 3'd7; spi_wdata = 8'h99;
    tick(); spi_wr_v = 1'b0;
    tick();
    check("frz_rf_en_on", rf_en, 1);
    ena = 1'b0; #1;
    check("frz_rf_en_masked", rf_en, 0);
    check("frz_rf_addr_masked", rf_addr, 0);
    tick(); tick();
    check("frz_rf_en_held", rf_en, 0);
    check("frz_mem7_untouched", mem[7], 0);
    ena = 1'b1; #1;
    check("frz_resume_rf_en", rf_en, 1);
    check("frz_resume_wdata", rf_wdata, 8'h99);
    tick(); tick();
    check("frz_mem7", mem[7], 8'h99);

    // SPI and core request in the same cycle, issued while an SPI access is in SPI_ACC
    spi_wr_v = 1'b1; spi_addr = 3'd3; spi_wdata = 8'h11;
    tick(); spi_wr_v = 1'b0;
    tick();
    check("mix_first_acc", rf_en, 1);
    spi_rd_v = 1'b1; spi_addr = 3'd3;
    core_req = 1'b1; core_we = 1'b0; core_addr = 3'd1;
    tick(); spi_rd_v = 1'b0;
    check("mix_rsp_gnt", core_gnt, 0);
    tick();
    check("mix_idle_gnt", core_gnt, 0);
    tick();
    check("mix_spi_first", rf_en, 1);
    check("mix_spi_addr", rf_addr, 3);
    check("mix_spi_gnt", core_gnt, 0);
    tick(); tick();
    check("mix_spi_rdata", spi_rdata, 8'h11);
    check("mix_idle2_gnt", core_gnt, 0);
    tick();
    check("mix_core_gnt", core_gnt, 1);
    check("mix_core_addr", rf_addr, 1);
    check("mix_core_rvalid0", core_rvalid, 0);
    core_req = 1'b0;
    tick();
    check("mix_core_rvalid", core_rvalid, 1);
    check("mix_core_rdata", core_rdata, 8'h5A);
    check("mix_gnt_off", core_gnt, 0);
    tick();
    check("mix_rvalid_off", core_rvalid, 0);
    check("mix_rdata_held", core_rdata, 8'h5A);

    // Saturating SPI traffic while the core waits
    rstb = 1'b0; tick(); rstb = 1'b1;
    spi_wr_v = 1'b1; spi_addr = 3'd4; spi_wdata = 8'h44;
    tick();
    core_req = 1'b1; core_we = 1'b1; core_addr = 3'd0; core_wdata = 8'hEE;
    spi_grants = 0; gnt_count = 0; first_gnt_spi = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rf_en && !core_gnt) spi_grants++;
      if (core_gnt) begin
        if (gnt_count == 0) first_gnt_spi = spi_grants;
        gnt_count++;
        core_req = 1'b0;
      end
    end
    spi_wr_v = 1'b0; core_req = 1'b0;
`ifdef SPI_ARB_STARVE_GUARD_EN
    check("starve_core_gnts", gnt_count, 1);
    check("starve_spi_before_gnt", first_gnt_spi, 4);
`else
    check("strict_core_gnts", gnt_count, 0);
    check("strict_spi_busy", spi_grants >= 10, 1);
`endif
    check("sat_ovf", ovf, 1);
    repeat (6) tick();

    // Back-to-back SPI writes: the second is dropped and ovf sticks
    rstb = 1'b0; tick();
    check("ovf_reset", ovf, 0);
    rstb = 1'b1;
    spi_wr_v = 1'b1; spi_addr = 3'd0; spi_wdata = 8'h01;
    tick(); spi_wdata = 8'h02;
    tick(); spi_wr_v = 1'b0;
    check("drop_ovf", ovf, 1);
    check("drop_first_wdata", rf_wdata, 8'h01);
    repeat (5) tick();
    check("drop_no_second", rf_en, 0);
    check("drop_ovf_sticky", ovf, 1);
    check("drop_mem0", mem[0], 8'h01);

    // Reset during CORE_ACC abandons the access
    rstb = 1'b0; tick();
    check("pre_ovf_clr", ovf, 0);
    rstb = 1'b1;
    core_req = 1'b1; core_we = 1'b0; core_addr = 3'd1;
    tick();
    check("ra_core_gnt", core_gnt, 1);
    rstb = 1'b0;
    tick();
    check("ra_rvalid", core_rvalid, 0);
    check("ra_rf_en", rf_en, 0);
    check("ra_core_gnt_off", core_gnt, 0);
    check("ra_rf_addr", rf_addr, 0);
    check("ra_core_rdata", core_rdata, 0);
    core_req = 1'b0; rstb = 1'b1;
    tick();
    check("ra_no_late_rvalid", core_rvalid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_reg_arbiter.md
SPI_REG_ARBITER -- requirements
Module: spi_reg_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 3, register address width.
REQ-002 SHALL have parameter REG_W, default 8, register data width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, consecutive SPI grants tolerated while core waits.
REQ-004 clk  input  1  system clock; all logic on posedge.
REQ-005 rstb  input  1  reset, synchronous, active-low.
REQ-006 ena  input  1  global enable; 0 freezes all state.
REQ-007 spi_addr  input  ADDR_W  SPI-side register address.
REQ-008 spi_rd_v  input  1  one-cycle pulse: SPI read request at spi_addr.
REQ-009 spi_wdata  input  REG_W  SPI-side write data.
REQ-010 spi_wr_v  input  1  one-cycle pulse: SPI write request at spi_addr.
REQ-011 spi_rdata  output  REG_W  last SPI read result, held until next SPI read completes.
REQ-012 core_req  input  1  level: core requests access; held until core_gnt.
REQ-013 core_we  input  1  core write (1) / read (0); stable while core_req.
REQ-014 core_addr  input  ADDR_W  core address; stable while core_req.
REQ-015 core_wdata  input  REG_W  core write data; stable while core_req.
REQ-016 core_gnt  output  1  one-cycle pulse: core access issued.
REQ-017 core_rvalid  output  1  one-cycle pulse: core_rdata valid (reads only).
REQ-018 core_rdata  output  REG_W  core read result.
REQ-019 rf_en / rf_we  output  1 / 1  register-file access strobe / write qualifier.
REQ-020 rf_addr / rf_wdata  output  ADDR_W / REG_W  register-file address / write data.
REQ-021 rf_rdata  input  REG_W  register-file read data, valid one cycle after rf_en.
REQ-022 ovf  output  1  sticky: SPI request dropped; cleared only by reset.

Function
REQ-023 SPI requests SHALL be latched into a one-entry pending slot (addr, wdata, we) the cycle the pulse is seen; spi_wr_v wins if both pulse together.
REQ-024 A SPI pulse arriving while the slot is occupied SHALL be dropped and set ovf; a pulse in the cycle the slot is consumed (SPI_ACC) SHALL be accepted.
REQ-025 FSM states: IDLE, SPI_ACC, SPI_RSP, CORE_ACC, CORE_RSP.
REQ-026 IDLE: slot full -> SPI_ACC; else core_req -> CORE_ACC; else stay. Slot filled this cycle is seen next cycle.
REQ-027 SPI_ACC: rf_en=1, rf_we/rf_addr/rf_wdata from slot, slot cleared, -> SPI_RSP.
REQ-028 SPI_RSP: if read, spi_rdata <= rf_rdata; -> IDLE. SPI read latency pulse-to-spi_rdata = 3 cycles from idle.
REQ-029 CORE_ACC: rf_en=1, core_gnt=1, fields from core_*, -> CORE_RSP.
REQ-030 CORE_RSP: if read, core_rdata <= rf_rdata and core_rvalid=1; -> IDLE.
REQ-031 rf_en, core_gnt, core_rvalid SHALL be 0 in all other states; rf_addr/rf_wdata/rf_we 0 when rf_en=0.
REQ-032 ena=0: state, slot, counters, data registers hold; rf_en/core_gnt/core_rvalid forced 0; SPI pulses ignored (not counted as ovf).
REQ-033 Exactly one rf access SHALL be in flight; back-to-back accesses separated by one RSP cycle plus one IDLE cycle.

Reset
REQ-034 rstb=0 at posedge clk: state IDLE, slot empty, ovf=0, starve count 0, spi_rdata/core_rdata=0, all strobes 0.
REQ-035 Reset mid-access SHALL abandon the access without a response pulse; rstb overrides ena.

Configuration
REQ-036 Macro SPI_ARB_STARVE_GUARD_EN defined: counter increments on each SPI grant made while core_req=1, clears on core grant; at STARVE_LIMIT, IDLE grants core ahead of a full slot.
REQ-037 Macro undefined: strict SPI priority, no counter logic.

Verification
REQ-038 spi_wr_v addr=5 data=0xA5 -> rf_en, rf_we=1, rf_addr=5, rf_wdata=0xA5 two cycles later; no core pulses.
REQ-039 rf holds 0x3C at 2, spi_rd_v addr=2 -> spi_rdata=0x3C three cycles after pulse, held afterwards.
REQ-040 core_req read addr=1 and spi_rd_v same cycle -> SPI access first, core_gnt after SPI_RSP+IDLE, core_rvalid next cycle.
REQ-041 Two spi_wr_v pulses one cycle apart -> second dropped, ovf=1 sticky until rstb=0.
REQ-042 Guard on, core_req held, SPI slot refilled continuously -> core_gnt after exactly 4 SPI grants; guard off -> no core_gnt while SPI saturates.
REQ-043 rstb=0 during CORE_ACC -> no core_rvalid, all outputs 0 next cycle.
